// File: rtl/guess_pkg.sv
// -----------------------------------------------------------------------------
// guess_pkg
// Shared definitions for the two-player number-guessing turn scheduler.
//   state_t      : scheduler state, encoded as it appears on the state port
//   WIN_*        : codes driven on the winner port
//   DEF_*        : default parameter values for guess_turn_sched
//   sat_inc8     : 8-bit increment that sticks at 255
// -----------------------------------------------------------------------------
package guess_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_REND  = 3'd4,
    ST_MEND  = 3'd5
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P0   = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;

  localparam int DEF_MAX_ATT       = 8;
  localparam int DEF_WIN_SCORE     = 3;
  localparam int DEF_SEED_CYCLES   = 4;
  localparam int DEF_CHECK_TIMEOUT = 16;
  localparam int DEF_TURN_TIMEOUT  = 1000;

  // Score counters never wrap: a player at 255 stays at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/guess_edge_det.sv
// -----------------------------------------------------------------------------
// guess_edge_det
// Registered rising-edge detector for a level button input.
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   din  : level input (player enter button)
//   rise : high for one cycle after din is first seen high
// The input is registered once (cur_reg) and compared with its previous
// registered value (prev_reg), so rise comes one cycle after din is sampled.
// -----------------------------------------------------------------------------
module guess_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic cur_reg;
  logic prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_reg  <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      cur_reg  <= din;
      prev_reg <= cur_reg;
    end
  end

  assign rise = cur_reg & ~prev_reg;

endmodule

// File: rtl/guess_turn_sched.sv
// -----------------------------------------------------------------------------
// guess_turn_sched
// Two-player turn scheduler in front of a shared guess datapath. Decides whose
// enter reaches the datapath, sequences seeding and round resets, counts
// wrong attempts, keeps per-player scores and declares the match winner.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : level; starts a match from IDLE or MEND
//   p0_enter, p1_enter    : player enter buttons (levels, edge-detected here)
//   dp_eq/lt/gt/outrange  : datapath verdicts for the last dp_enter
//   dp_enter              : one-cycle enter pulse to the datapath
//   dp_genrand            : datapath random-generate strobe
//   dp_rst                : one-cycle datapath round reset
//   turn                  : player currently allowed to guess
//   score0, score1        : rounds won per player (saturating)
//   attempts              : wrong guesses in the current round
//   round_over            : one-cycle pulse at the end of each round
//   winner                : 00 none, 01 player 0, 10 player 1
//   err                   : sticky verdict-timeout flag, cleared on start
//   state                 : IDLE 0, SEED 1, WAIT 2, CHECK 3, REND 4, MEND 5
//
// Build option: define TURN_TIMER_EN to forfeit a turn after TURN_TIMEOUT
// idle cycles in WAIT. Without it WAIT waits indefinitely.
// -----------------------------------------------------------------------------
module guess_turn_sched
  import guess_pkg::*;
#(
  parameter int MAX_ATT       = DEF_MAX_ATT,
  parameter int WIN_SCORE     = DEF_WIN_SCORE,
  parameter int SEED_CYCLES   = DEF_SEED_CYCLES,
  parameter int CHECK_TIMEOUT = DEF_CHECK_TIMEOUT,
  parameter int TURN_TIMEOUT  = DEF_TURN_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       p0_enter,
  input  logic       p1_enter,
  input  logic       dp_eq,
  input  logic       dp_lt,
  input  logic       dp_gt,
  input  logic       dp_outrange,
  output logic       dp_enter,
  output logic       dp_genrand,
  output logic       dp_rst,
  output logic       turn,
  output logic [7:0] score0,
  output logic [7:0] score1,
  output logic [3:0] attempts,
  output logic       round_over,
  output logic [1:0] winner,
  output logic       err,
  output logic [2:0] state
);

`ifdef TURN_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  localparam logic [3:0] MAX_ATT_L  = 4'(MAX_ATT);
  localparam logic [7:0] WIN_L      = 8'(WIN_SCORE);
  localparam logic [3:0] SEED_L     = 4'(SEED_CYCLES);
  localparam logic [7:0] CHK_LAST   = 8'(CHECK_TIMEOUT - 1);
  localparam int         TT_W       = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam logic [TT_W-1:0] TT_LAST = TT_W'(TURN_TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // Enter edge detection, one detector per player
  // ---------------------------------------------------------------------------
  logic [1:0] enter_raw;
  logic [1:0] enter_rise;

  assign enter_raw = {p1_enter, p0_enter};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_edge
      guess_edge_det u_det (
        .clk  (clk),
        .rst  (rst),
        .din  (enter_raw[gi]),
        .rise (enter_rise[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t          state_reg;
  logic            dp_enter_reg;
  logic            dp_genrand_reg;
  logic            dp_rst_reg;
  logic            turn_reg;
  logic            starter_reg;
  logic [7:0]      score_reg [2];
  logic [3:0]      attempts_reg;
  logic            round_over_reg;
  logic [1:0]      winner_reg;
  logic            err_reg;
  logic [3:0]      seed_cnt_reg;
  logic [7:0]      vcnt_reg;
  logic [TT_W-1:0] tcnt_reg;

  // Only the player holding the turn gets through; a simultaneous edge from
  // the other player is simply discarded.
  logic       accepted;
  logic [3:0] att_inc;
  logic       att_limit;
  logic       turn_expired;

  assign accepted     = enter_rise[turn_reg];
  assign att_inc      = attempts_reg + 4'd1;
  assign att_limit    = (att_inc == MAX_ATT_L);
  assign turn_expired = TIMER_EN && (tcnt_reg == TT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      dp_enter_reg   <= 1'b0;
      dp_genrand_reg <= 1'b0;
      dp_rst_reg     <= 1'b0;
      turn_reg       <= 1'b0;
      starter_reg    <= 1'b0;
      score_reg[0]   <= 8'd0;
      score_reg[1]   <= 8'd0;
      attempts_reg   <= 4'd0;
      round_over_reg <= 1'b0;
      winner_reg     <= WIN_NONE;
      err_reg        <= 1'b0;
      seed_cnt_reg   <= 4'd0;
      vcnt_reg       <= 8'd0;
      tcnt_reg       <= '0;
    end else begin
      // single-cycle pulses fall back low unless re-asserted below
      dp_enter_reg   <= 1'b0;
      dp_rst_reg     <= 1'b0;
      round_over_reg <= 1'b0;

      // the turn timer only measures uninterrupted time spent in WAIT
      if (state_reg != ST_WAIT) begin
        tcnt_reg <= '0;
      end

      case (state_reg)
        ST_IDLE, ST_MEND: begin
          if (start) begin
            dp_rst_reg     <= 1'b1;
            dp_genrand_reg <= 1'b0;
            score_reg[0]   <= 8'd0;
            score_reg[1]   <= 8'd0;
            err_reg        <= 1'b0;
            winner_reg     <= WIN_NONE;
            seed_cnt_reg   <= 4'd0;
            state_reg      <= ST_SEED;
          end
        end

        // First SEED cycle carries dp_rst; genrand then stays high for
        // SEED_CYCLES cycles and drops on the way out to WAIT.
        ST_SEED: begin
          if (seed_cnt_reg == SEED_L) begin
            dp_genrand_reg <= 1'b0;
            attempts_reg   <= 4'd0;
            turn_reg       <= starter_reg;
            state_reg      <= ST_WAIT;
          end else begin
            dp_genrand_reg <= 1'b1;
            seed_cnt_reg   <= seed_cnt_reg + 4'd1;
          end
        end

        ST_WAIT: begin
          if (accepted) begin
            dp_enter_reg <= 1'b1;
            vcnt_reg     <= 8'd0;
            tcnt_reg     <= '0;
            state_reg    <= ST_CHECK;
          end else if (turn_expired) begin
            // forfeit counts exactly like a wrong guess
            tcnt_reg     <= '0;
            attempts_reg <= att_inc;
            if (att_limit) begin
              round_over_reg <= 1'b1;
              state_reg      <= ST_REND;
            end else begin
              turn_reg <= ~turn_reg;
            end
          end else if (TIMER_EN) begin
            tcnt_reg <= tcnt_reg + 1'b1;
          end
        end

        // The cycle in which dp_enter is high belongs to the datapath; the
        // verdict lines are only trusted from the following cycle on.
        ST_CHECK: begin
          if (!dp_enter_reg) begin
            if (dp_eq) begin
              score_reg[turn_reg] <= sat_inc8(score_reg[turn_reg]);
              round_over_reg      <= 1'b1;
              state_reg           <= ST_REND;
            end else if (dp_outrange) begin
              state_reg <= ST_WAIT;
            end else if (dp_lt || dp_gt) begin
              attempts_reg <= att_inc;
              if (att_limit) begin
                round_over_reg <= 1'b1;
                state_reg      <= ST_REND;
              end else begin
                turn_reg  <= ~turn_reg;
                state_reg <= ST_WAIT;
              end
            end else if (vcnt_reg == CHK_LAST) begin
              // silent datapath: flag it and give the same player another go
              err_reg   <= 1'b1;
              state_reg <= ST_WAIT;
            end else begin
              vcnt_reg <= vcnt_reg + 8'd1;
            end
          end
        end

        ST_REND: begin
          starter_reg <= ~starter_reg;
          if (score_reg[0] == WIN_L) begin
            winner_reg <= WIN_P0;
            state_reg  <= ST_MEND;
          end else if (score_reg[1] == WIN_L) begin
            winner_reg <= WIN_P1;
            state_reg  <= ST_MEND;
          end else begin
            dp_rst_reg   <= 1'b1;
            seed_cnt_reg <= 4'd0;
            state_reg    <= ST_SEED;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign dp_enter   = dp_enter_reg;
  assign dp_genrand = dp_genrand_reg;
  assign dp_rst     = dp_rst_reg;
  assign turn       = turn_reg;
  assign score0     = score_reg[0];
  assign score1     = score_reg[1];
  assign attempts   = attempts_reg;
  assign round_over = round_over_reg;
  assign winner     = winner_reg;
  assign err        = err_reg;
  assign state      = state_reg;

endmodule

// File: doc/guess_turn_sched.md
Name: guess_turn_sched

Overview:
Two-player turn scheduler for the number-guessing datapath. Both players share one DIP/enter/genrand datapath. The scheduler decides whose enter reaches the datapath, sequences seeding and round resets, and counts attempts. It also keeps per-player scores and declares a match winner. It sits between the players' enter buttons and the guess datapath, and drives the datapath's enter, genrand and rst inputs.

Parameters:
MAX_ATT, 8, combined wrong guesses allowed per round before the round is void (1..15)
WIN_SCORE, 3, rounds a player must win to take the match (1..255)
SEED_CYCLES, 4, cycles dp_genrand is held high per round (1..15)
CHECK_TIMEOUT, 16, cycles to wait for a datapath verdict after dp_enter (2..255)
TURN_TIMEOUT, 1000, idle cycles before a turn is forfeited (only with TURN_TIMER_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  level; starts a match from IDLE or MATCH_END
p0_enter  in  1  player 0 enter, level; edge-detected internally
p1_enter  in  1  player 1 enter, level; edge-detected internally
dp_eq  in  1  datapath verdict: guess equals secret
dp_lt  in  1  datapath verdict: guess below secret
dp_gt  in  1  datapath verdict: guess above secret
dp_outrange  in  1  datapath verdict: guess outside the current LL..HL window
dp_enter  out  1  one-cycle pulse to the datapath enter input
dp_genrand  out  1  datapath random-generate strobe
dp_rst  out  1  one-cycle datapath round reset
turn  out  1  player currently allowed to guess
score0  out  8  rounds won by player 0
score1  out  8  rounds won by player 1
attempts  out  4  wrong guesses so far in this round
round_over  out  1  one-cycle pulse at the end of each round
winner  out  2  00 none, 01 player 0, 10 player 1
err  out  1  sticky; set on a verdict timeout, cleared on start
state  out  3  encoding: IDLE 0, SEED 1, WAIT 2, CHECK 3, REND 4, MEND 5

Behaviour:
- Reset (async): state=IDLE. All outputs 0, including turn=0 and winner=00. Starter register=0.
- Enter edges: each input is registered once; an edge is cur & ~prev. Only the edge from the player equal to turn is accepted. An edge from the other player is dropped, including when both arrive in the same cycle.
- IDLE: on start, dp_rst=1 for one cycle, scores and err clear, go to SEED.
- SEED: dp_genrand=1 for exactly SEED_CYCLES cycles, then low. On exit: attempts=0, turn=starter, go to WAIT.
- WAIT: an accepted edge drives dp_enter=1 for the next cycle only, clears the verdict counter, then go to CHECK.
- CHECK: sample verdicts each cycle from the cycle after dp_enter. Priority is eq > outrange > lt/gt.
  - eq: score[turn]+1 (saturate at 255), go to REND.
  - outrange: no attempt charged, turn unchanged, go to WAIT.
  - lt or gt: attempts+1. If the new value equals MAX_ATT, go to REND with no score. Otherwise toggle turn and go to WAIT.
  - No verdict within CHECK_TIMEOUT cycles: set err, treat as outrange.
- REND: round_over=1 for one cycle and the starter toggles.
  - If either score equals WIN_SCORE: set winner and go to MEND.
  - Otherwise dp_rst=1 for one cycle and go to SEED.
- MEND: winner and scores hold. start behaves as in IDLE.
- start is ignored outside IDLE and MEND.
- Enter edges outside WAIT are ignored and are not queued.
- Reset asserted mid-round aborts immediately. dp_* outputs go low the same instant.
- Latency from an accepted enter edge to dp_enter is 2 cycles (edge register plus output register).

Optional Feature:
TURN_TIMER_EN:
- Defined: a counter runs in WAIT and clears on each accepted edge. When it reaches TURN_TIMEOUT, the turn is forfeited: attempts+1 (with the MAX_ATT check as for a wrong guess), turn toggles, and the counter resets.
- Undefined: WAIT waits indefinitely. TURN_TIMEOUT is unused.

Decomposition:
- Shared package guess_pkg holds:
  - the state enum (3-bit, encodings above)
  - winner codes WIN_NONE=2'b00, WIN_P0=2'b01, WIN_P1=2'b10
  - the default MAX_ATT and WIN_SCORE constants
- One sub-module: guess_edge_det, a registered rising-edge detector instantiated for p0_enter and p1_enter.

Test Plan:
1. rst, then start → dp_rst for 1 cycle, dp_genrand high for 4 cycles, state=WAIT, turn=0, attempts=0.
2. p0 enter with dp_gt on the next-but-one cycle → attempts=1, turn=1. A p0 enter while turn=1 → no dp_enter pulse.
3. Turn=1, p1 enter with dp_eq → score1=1, round_over pulse, dp_rst pulse. Next round starts with turn=1 (alternating starter).
4. dp_outrange verdict → attempts unchanged, turn unchanged. No verdict for 16 cycles → err=1, state returns to WAIT.
5. Eight alternating dp_lt verdicts → round_over, scores unchanged. Three eq wins by p0 → winner=01, state=MEND. start → scores=0, err=0.
6. rst asserted in CHECK → state=IDLE, all outputs 0 asynchronously. With TURN_TIMER_EN, 1000 idle cycles in WAIT → turn toggles and attempts+1.
